// File: rtl/keyword_filter.sv
// keyword_filter: store-and-forward AXI-Stream stage that buffers one frame,
// scans it for a byte keyword (including matches that straddle beat
// boundaries), raises an allow/deny verdict that waits for an ack, and then
// replays the stored frame unchanged.
module keyword_filter #(
    parameter logic [63:0] KEYWORD     = 64'h0000_7465_7263_6573,
    parameter int          KEYWORD_LEN = 6,
    parameter int          DEPTH       = 64,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             allow_sig,
    output logic             deny_sig,
    input  logic             ack,
    output logic [CNT_W-1:0] allowed_count,
    output logic [CNT_W-1:0] denied_count
);

    // DEPTH is a power of two >= 2; wr_cnt carries one extra bit so that a
    // completely full buffer is distinguishable from an empty one.
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        RECV,
        DECIDE,
        SEND
    } state_t;

    state_t state;

    // Frame buffer
    logic [63:0] data_mem [DEPTH];
    logic [7:0]  keep_mem [DEPTH];
    logic        last_mem [DEPTH];
    logic        user_mem [DEPTH];

    logic [AW:0]   wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          trunc;
    logic          match_flag;

    // Byte history: hist[6] is the newest byte, hist_cnt counts how many of
    // the slots hold real bytes of the current frame (right-aligned).
    logic [6:0][7:0] hist;
    logic [2:0]      hist_cnt;

    logic in_fire, out_fire, buf_full, frame_deny;

    assign in_fire  = s_axis_tvalid & s_axis_tready;
    assign out_fire = m_axis_tvalid & m_axis_tready;
    assign buf_full = (wr_cnt == FULL_CNT);

    // ------------------------------------------------------------------
    // Matching window: 7 history bytes followed by the 8 bytes of the beat.
    // ------------------------------------------------------------------
    logic [7:0]      win [15];
    logic [14:0]     win_v;
    logic [3:0]      nvalid;
    logic [3:0]      hist_sum;
    logic [6:0][7:0] hist_nx;
    logic [2:0]      hist_cnt_nx;
    logic            beat_match;
    logic            hit;

    // Build the window, look for a keyword ending in the current beat and
    // compute the history after shifting in this beat's valid bytes.
    always_comb begin
        nvalid      = '0;
        beat_match  = 1'b0;
        hit         = 1'b0;
        hist_nx     = hist;
        hist_cnt_nx = hist_cnt;
        for (int j = 0; j < 8; j++)
            nvalid = nvalid + {3'b000, s_axis_tkeep[j]};
        for (int i = 0; i < 7; i++) begin
            win[i]   = hist[i];
            win_v[i] = (i >= 7 - int'(hist_cnt));
        end
        for (int j = 0; j < 8; j++) begin
            win[7+j]   = s_axis_tdata[8*j +: 8];
            win_v[7+j] = s_axis_tkeep[j];
        end
        // A candidate ending at window slot 7+j starts at slot 8+j-KEYWORD_LEN;
        // its last byte being valid guarantees it ends inside the current beat.
        for (int j = 0; j < 8; j++) begin
            hit = 1'b1;
            for (int k = 0; k < KEYWORD_LEN; k++) begin
                if (!win_v[8+j-KEYWORD_LEN+k] ||
                    (win[8+j-KEYWORD_LEN+k] != KEYWORD[8*k +: 8]))
                    hit = 1'b0;
            end
            if (hit)
                beat_match = 1'b1;
        end
        // The concatenated valid bytes end at slot 6+nvalid; keep the last 7.
        for (int k = 0; k < 7; k++)
            hist_nx[k] = win[int'(nvalid) + k];
        hist_sum    = {1'b0, hist_cnt} + nvalid;
        hist_cnt_nx = (hist_sum > 4'd7) ? 3'd7 : hist_sum[2:0];
    end

    // Deny when the keyword was seen anywhere in the frame, the frame did not
    // fit, or the source flagged the final beat as bad.
    assign frame_deny = match_flag | beat_match | trunc | buf_full | s_axis_tuser;

    // ------------------------------------------------------------------
    // Replay read side: DECIDE preloads beat 0, SEND walks forward.
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_idx;
    logic          force_end;

    assign rd_idx    = (state == SEND) ? rd_cnt : '0;
    assign force_end = trunc & (rd_idx == LAST_IDX);

    // Store accepted beats while there is room; overflow beats are dropped.
    always_ff @(posedge clk) begin
        if (!reset && in_fire && !buf_full) begin
            data_mem[wr_cnt[AW-1:0]] <= s_axis_tdata;
            keep_mem[wr_cnt[AW-1:0]] <= s_axis_tkeep;
            last_mem[wr_cnt[AW-1:0]] <= s_axis_tlast;
            user_mem[wr_cnt[AW-1:0]] <= s_axis_tuser;
        end
    end

    // Control FSM: receive and scan, hold the verdict until ack, replay.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RECV;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            allow_sig     <= 1'b0;
            deny_sig      <= 1'b0;
            allowed_count <= '0;
            denied_count  <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            trunc         <= 1'b0;
            match_flag    <= 1'b0;
            hist          <= '0;
            hist_cnt      <= '0;
        end else begin
            case (state)
                RECV: begin
                    s_axis_tready <= 1'b1;
                    if (in_fire) begin
                        if (buf_full)
                            trunc <= 1'b1;
                        else
                            wr_cnt <= wr_cnt + 1'b1;
                        if (s_axis_tlast) begin
                            allow_sig     <= ~frame_deny;
                            deny_sig      <= frame_deny;
                            s_axis_tready <= 1'b0;
                            match_flag    <= 1'b0;
                            hist          <= '0;
                            hist_cnt      <= '0;
                            state         <= DECIDE;
                        end else begin
                            if (beat_match)
                                match_flag <= 1'b1;
                            hist     <= hist_nx;
                            hist_cnt <= hist_cnt_nx;
                        end
                    end
                end
                DECIDE: begin
                    if (ack) begin
                        if (allow_sig)
                            allowed_count <= allowed_count + 1'b1;
                        if (deny_sig)
                            denied_count <= denied_count + 1'b1;
                        allow_sig     <= 1'b0;
                        deny_sig      <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= data_mem[rd_idx];
                        m_axis_tkeep  <= keep_mem[rd_idx];
                        m_axis_tlast  <= last_mem[rd_idx] | force_end;
                        m_axis_tuser  <= user_mem[rd_idx] | force_end;
                        rd_cnt        <= AW'(1);
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            s_axis_tready <= 1'b1;
                            wr_cnt        <= '0;
                            trunc         <= 1'b0;
                            state         <= RECV;
                        end else begin
                            m_axis_tdata <= data_mem[rd_idx];
                            m_axis_tkeep <= keep_mem[rd_idx];
                            m_axis_tlast <= last_mem[rd_idx] | force_end;
                            m_axis_tuser <= user_mem[rd_idx] | force_end;
                            rd_cnt       <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_keyword_filter.sv
// Directed bench for keyword_filter: a table of frames (beats, expected
// verdict, expected replay shape) plus hand-written backpressure and
// mid-replay reset sequences. Built with DEPTH=4 so overflow is reachable.
module tb_keyword_filter;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [63:0]      s_axis_tdata;
    logic [7:0]       s_axis_tkeep;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic             s_axis_tuser;
    logic [63:0]      m_axis_tdata;
    logic [7:0]       m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             allow_sig;
    logic             deny_sig;
    logic             ack;
    logic [CNT_W-1:0] allowed_count;
    logic [CNT_W-1:0] denied_count;

    keyword_filter #(
        .KEYWORD    (64'h0000_7465_7263_6573),
        .KEYWORD_LEN(6),
        .DEPTH      (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .allow_sig    (allow_sig),
        .deny_sig     (deny_sig),
        .ack          (ack),
        .allowed_count(allowed_count),
        .denied_count (denied_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              nbeats;
        logic [5:0][63:0] data;
        logic [5:0][7:0]  keep;
        logic            tuser;
        logic            exp_deny;
        int              exp_nrep;
        logic            exp_last_user;
    } frame_t;

    frame_t tbl [10];
    int n_pass = 0;
    int n_total = 0;
    int exp_allowed = 0;
    int exp_denied = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_frame(input int i, input string nm, input int n, input logic u,
                             input logic dn, input int nrep, input logic lu);
        tbl[i].name          = nm;
        tbl[i].nbeats        = n;
        tbl[i].data          = '0;
        tbl[i].keep          = '0;
        tbl[i].tuser         = u;
        tbl[i].exp_deny      = dn;
        tbl[i].exp_nrep      = nrep;
        tbl[i].exp_last_user = lu;
    endtask

    task automatic set_beat(input int i, input int b, input logic [63:0] d, input logic [7:0] k);
        tbl[i].data[b] = d;
        tbl[i].keep[b] = k;
    endtask

    // Present the beats, then check the verdict one cycle after tlast accept.
    task automatic send_and_verdict(input int i);
        int stalls;
        int guard;
        stalls = 0;
        for (int b = 0; b < tbl[i].nbeats; b++) begin
            s_axis_tdata  = tbl[i].data[b];
            s_axis_tkeep  = tbl[i].keep[b];
            s_axis_tlast  = (b == tbl[i].nbeats - 1);
            s_axis_tuser  = (b == tbl[i].nbeats - 1) ? tbl[i].tuser : 1'b0;
            s_axis_tvalid = 1'b1;
            ack           = 1'b1;   // ack outside DECIDE must be ignored
            guard = 0;
            while (!s_axis_tready && guard < 20) begin
                step();
                guard++;
                if (b > 0) stalls++;
            end
            if (guard >= 20) stalls += 100;
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        ack           = 1'b0;
        chk({tbl[i].name, "_in_stalls"}, 64'(stalls), 64'd0);
        chk({tbl[i].name, "_tready_low"}, 64'(s_axis_tready), 64'd0);
        chk({tbl[i].name, "_allow"}, 64'(allow_sig), 64'(!tbl[i].exp_deny));
        chk({tbl[i].name, "_deny"}, 64'(deny_sig), 64'(tbl[i].exp_deny));
        repeat (3) step();
        chk({tbl[i].name, "_allow_hold"}, 64'(allow_sig), 64'(!tbl[i].exp_deny));
        chk({tbl[i].name, "_deny_hold"}, 64'(deny_sig), 64'(tbl[i].exp_deny));
    endtask

    task automatic do_ack(input int i);
        ack = 1'b1;
        step();
        ack = 1'b0;
        if (tbl[i].exp_deny) exp_denied++;
        else exp_allowed++;
        chk({tbl[i].name, "_verdict_drop"}, 64'({allow_sig, deny_sig}), 64'd0);
        chk({tbl[i].name, "_mvalid_up"}, 64'(m_axis_tvalid), 64'd1);
        chk({tbl[i].name, "_allowed_cnt"}, 64'(allowed_count), 64'(exp_allowed));
        chk({tbl[i].name, "_denied_cnt"}, 64'(denied_count), 64'(exp_denied));
    endtask

    task automatic check_beat(input int i, input int r);
        logic is_last;
        is_last = (r == tbl[i].exp_nrep - 1);
        chk($sformatf("%s_r%0d_data", tbl[i].name, r), m_axis_tdata, tbl[i].data[r]);
        chk($sformatf("%s_r%0d_keep", tbl[i].name, r), 64'(m_axis_tkeep), 64'(tbl[i].keep[r]));
        chk($sformatf("%s_r%0d_last", tbl[i].name, r), 64'(m_axis_tlast), 64'(is_last));
        chk($sformatf("%s_r%0d_user", tbl[i].name, r), 64'(m_axis_tuser),
            64'(is_last ? tbl[i].exp_last_user : 1'b0));
    endtask

    // Drain the replay with the sink always ready.
    task automatic replay_all(input int i);
        int guard;
        m_axis_tready = 1'b1;
        for (int r = 0; r < tbl[i].exp_nrep; r++) begin
            guard = 0;
            while (!m_axis_tvalid && guard < 20) begin
                step();
                guard++;
            end
            chk($sformatf("%s_r%0d_valid", tbl[i].name, r), 64'(m_axis_tvalid), 64'd1);
            check_beat(i, r);
            step();
        end
        m_axis_tready = 1'b0;
        chk({tbl[i].name, "_mvalid_done"}, 64'(m_axis_tvalid), 64'd0);
        chk({tbl[i].name, "_tready_back"}, 64'(s_axis_tready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  pat;
        logic [63:0] prev;
        logic        have_prev;
        int          got;
        int          c;

        // Frame table
        set_frame(0, "allow2", 2, 1'b0, 1'b0, 2, 1'b0);
        set_beat (0, 0, 64'h0706050403020100, 8'hFF);
        set_beat (0, 1, 64'h00000000000A0908, 8'h07);
        set_frame(1, "inbeat", 1, 1'b0, 1'b1, 1, 1'b0);
        set_beat (1, 0, 64'h0074657263657341, 8'hFF);
        set_frame(2, "cross", 2, 1'b0, 1'b1, 2, 1'b0);
        set_beat (2, 0, 64'h6365734444444444, 8'hFF);
        set_beat (2, 1, 64'h0000000000746572, 8'h07);
        set_frame(3, "split_a", 1, 1'b0, 1'b0, 1, 1'b0);
        set_beat (3, 0, 64'h6365734444444444, 8'hFF);
        set_frame(4, "split_b", 1, 1'b0, 1'b0, 1, 1'b0);
        set_beat (4, 0, 64'h0000000000746572, 8'h07);
        set_frame(5, "overflow", 6, 1'b0, 1'b1, 4, 1'b1);
        set_beat (5, 0, 64'h1111111111111111, 8'hFF);
        set_beat (5, 1, 64'h2222222222222222, 8'hFF);
        set_beat (5, 2, 64'h3333333333333333, 8'hFF);
        set_beat (5, 3, 64'h4444444444444444, 8'hFF);
        set_beat (5, 4, 64'h5555555555555555, 8'hFF);
        set_beat (5, 5, 64'h6666666666666666, 8'hFF);
        set_frame(6, "tuser", 1, 1'b1, 1'b1, 1, 1'b1);
        set_beat (6, 0, 64'h0123456789ABCDEF, 8'hFF);
        set_frame(7, "keep0_gap", 3, 1'b0, 1'b1, 3, 1'b0);
        set_beat (7, 0, 64'h6365734444444444, 8'hFF);
        set_beat (7, 1, 64'h5555555555555555, 8'h00);
        set_beat (7, 2, 64'h0000000000746572, 8'h07);
        set_frame(8, "keep_mask", 1, 1'b0, 1'b0, 1, 1'b0);
        set_beat (8, 0, 64'h7465726365730000, 8'h3F);
        set_frame(9, "three", 3, 1'b0, 1'b0, 3, 1'b0);
        set_beat (9, 0, 64'hA0A1A2A3A4A5A6A7, 8'hFF);
        set_beat (9, 1, 64'hB0B1B2B3B4B5B6B7, 8'hFF);
        set_beat (9, 2, 64'h00000000C4C5C6C7, 8'h0F);

        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b0;
        ack           = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_out", {m_axis_tdata[55:0], m_axis_tkeep}, 64'd0);
        chk("rst_m_flags", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata[63:56]}), 64'd0);
        chk("rst_verdict", 64'({allow_sig, deny_sig}), 64'd0);
        chk("rst_counts", 64'({allowed_count, denied_count}), 64'd0);
        reset = 1'b0;
        step();
        chk("rst_release_tready", 64'(s_axis_tready), 64'd1);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            send_and_verdict(i);
            do_ack(i);
            replay_all(i);
        end

        // Backpressure: sink ready pattern 1,0,0,1,0,1 then held high
        send_and_verdict(9);
        do_ack(9);
        pat       = 6'b101001;
        got       = 0;
        c         = 0;
        have_prev = 1'b0;
        prev      = '0;
        while (got < 3 && c < 30) begin
            m_axis_tready = (c < 6) ? pat[c] : 1'b1;
            if (have_prev) begin
                chk($sformatf("bp_stable_c%0d", c), m_axis_tdata, prev);
                chk($sformatf("bp_valid_c%0d", c), 64'(m_axis_tvalid), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check_beat(9, got);
                got++;
                have_prev = 1'b0;
            end else if (m_axis_tvalid) begin
                prev      = m_axis_tdata;
                have_prev = 1'b1;
            end
            step();
            c++;
        end
        m_axis_tready = 1'b0;
        chk("bp_beats", 64'(got), 64'd3);
        chk("bp_mvalid_done", 64'(m_axis_tvalid), 64'd0);
        chk("bp_tready_back", 64'(s_axis_tready), 64'd1);

        // Reset in the middle of a replay, after one of three beats
        send_and_verdict(9);
        do_ack(9);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        chk("mid_beat1", m_axis_tdata, tbl[9].data[1]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_allowed = 0;
        exp_denied  = 0;
        chk("mid_rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_mlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_counts", 64'({allowed_count, denied_count}), 64'd0);
        send_and_verdict(1);
        do_ack(1);
        replay_all(1);
        send_and_verdict(0);
        do_ack(0);
        replay_all(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keyword_filter.md
Name: keyword_filter

Overview:
- Stage directly upstream of the access-control gate in the keyword-search path.
- Buffers one whole 64-bit AXI-Stream frame and scans it for a configured byte keyword, including matches that span beat boundaries.
- At end of frame it issues an allow or deny verdict and holds it until the gate acks.
- After the ack it replays the buffered frame unchanged toward the gate.

Parameters:
- KEYWORD, 64'h0000_7465_7263_6573, keyword bytes; byte 0 (bits 7:0) is the first byte on the wire. Default is "secret".
- KEYWORD_LEN, 6, keyword length in bytes, legal range 1..8.
- DEPTH, 64, frame buffer depth in beats, power of 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_axis_tdata  in  64  input frame data
- s_axis_tkeep  in  8  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of frame
- s_axis_tuser  in  1  input bad-frame flag
- m_axis_tdata  out  64  replayed data
- m_axis_tkeep  out  8  replayed byte enables
- m_axis_tvalid  out  1  replay valid
- m_axis_tready  in  1  replay ready
- m_axis_tlast  out  1  replay end of frame
- m_axis_tuser  out  1  replay bad-frame flag
- allow_sig  out  1  verdict: pass the frame
- deny_sig  out  1  verdict: drop the frame
- ack  in  1  verdict accepted by the gate
- allowed_count  out  CNT_W  frames allowed, wraps at 2^CNT_W
- denied_count  out  CNT_W  frames denied, wraps at 2^CNT_W

Behaviour:
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0.
  - allow_sig=0, deny_sig=0, both counters=0.
  - Buffer empty, state RECV.
- A mid-frame reset abandons both the inbound and the replayed frame; no partial tlast is emitted.
- s_axis_tready is registered: 1 from the first cycle after reset deasserts while in RECV, 0 in DECIDE and SEND.
- FSM RECV:
  - Each accepted beat (tvalid & tready) is written to the buffer at wr_ptr, and wr_ptr increments.
  - tkeep is contiguous from bit 0. Only the tlast beat may be partial.
  - A tkeep=0 beat is stored, but its bytes do not enter matching.
- Matching:
  - A 7-byte history register holds the last valid bytes of the current frame and is cleared at frame start.
  - Window = history followed by the current beat's valid bytes.
  - match_flag sets if KEYWORD_LEN consecutive window bytes equal KEYWORD[8*KEYWORD_LEN-1:0] and the sequence ends in a current-beat byte.
  - match_flag is sticky per frame and cleared at frame start.
  - The history shifts in the valid bytes of each beat.
- Overflow:
  - If a beat arrives while DEPTH beats are already stored, it is discarded.
  - tready stays 1 and the trunc flag is set.
  - Discarding continues until the tlast beat is accepted.
- On tlast accept: verdict = deny if match_flag, trunc, or tuser of that beat is set; otherwise allow. Go to DECIDE.
- FSM DECIDE:
  - allow_sig or deny_sig (exactly one) is registered high in the cycle after the tlast accept, i.e. 1-cycle latency.
  - It is held until ack is sampled high.
  - On that edge: drop the verdict, increment the matching counter, go to SEND.
  - ack while in RECV or SEND is ignored.
- FSM SEND:
  - m_axis_tvalid is asserted the cycle after the ack edge.
  - Beats are read in order. A beat advances only on m_axis_tvalid & m_axis_tready.
  - Data, tkeep and tuser are replayed bit-exact. tlast is as stored.
  - If trunc is set, beat DEPTH-1 is output with tlast=1 and tuser=1.
  - On the tlast handshake: buffer is emptied, flags cleared, state RECV, and s_axis_tready=1 the next cycle.
  - Output data and valid hold stable while m_axis_tready=0.
- Frames are never interleaved. A new frame is accepted only after the previous replay completes.

Test Plan:
1. Allow path: 2-beat frame, beat0=64'h0706050403020100 keep FF, beat1=64'h0A0908 keep 07 tlast. allow_sig=1 one cycle after the tlast accept and held. Ack 3 cycles later. Replay matches beat0/beat1 exactly (keep FF/07, tlast on beat1). allowed_count=1, deny_sig never set.
2. In-beat match: single beat 64'h0074_6572_6365_7341 tlast. deny_sig=1, not allow_sig. Frame replayed intact after ack. denied_count=1.
3. Cross-beat match: beat0 bytes 5..7="sec", beat1 bytes 0..2="ret" tlast. deny_sig=1. The same bytes split across two separate frames produce allow for both, proving the history is cleared.
4. Overflow with DEPTH=4: 6-beat frame with no keyword. s_axis_tready stays 1 through beat 6, then deny_sig=1. Replay is 4 beats, beat 3 has tlast=1 and tuser=1. denied_count increments.
5. Backpressure: 3-beat allowed frame, m_axis_tready toggled 1,0,0,1,0,1. No beat is lost or duplicated, and data is stable while stalled. s_axis_tready returns to 1 the cycle after the tlast handshake.
6. Reset mid-SEND after 1 of 3 beats: m_axis_tvalid=0 the next cycle, counters=0. A subsequent clean frame gets the correct verdict and replay.
